w_controller: RTL and testbench
===============================

Name: w_controller

Overview:
- Write-back (W) stage controller of the 5-stage MIPS32 pipelined CPU.
- Registers the instruction entering W and decodes it into:
  - hazard-unit timing fields (Tuse_rs, Tuse_rt, Tnew);
  - destination register (A3);
  - register-file write-data select (memtoreg);
  - jal flag (jalop).
- Its outputs feed the GRF write port mux and the forwarding/stall unit.

Parameters:
- none

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr  input  32  instruction leaving the M stage, captured into the W stage register
- Tuse_rs  output  2  cycles until rs is needed; 2'b11 = rs not used
- Tuse_rt  output  2  cycles until rt is needed; 2'b11 = rt not used
- Tnew  output  2  cycles until the W-stage result is available; always 0 in W
- A3  output  5  GRF destination register; 0 = no write
- memtoreg  output  2  GRF write-data select: 0 ALU result, 1 DM read data, 2 PC+8
- jalop  output  1  1 when the W-stage instruction is jal

Behaviour:
- Stage register
  - instr_w <= instr on every rising clk edge.
  - rst_n low clears instr_w to 32'h0 (nop) immediately, independent of clk.
  - All outputs are combinational decodes of instr_w, so they show instr one clock after capture.
- Decode fields: op = instr_w[31:26], funct = instr_w[5:0], rs = [25:21], rt = [20:16], rd = [15:11].
- Supported instructions (Tuse_rs / Tuse_rt / A3 / memtoreg / jalop):
  - addu (op 0, funct 100001): 1 / 1 / rd / 0 / 0
  - subu (op 0, funct 100011): 1 / 1 / rd / 0 / 0
  - jr (op 0, funct 001000): 0 / 3 / 0 / 0 / 0
  - ori (op 001101): 1 / 3 / rt / 0 / 0
  - lui (op 001111): 3 / 3 / rt / 0 / 0
  - lw (op 100011): 1 / 3 / rt / 1 / 0
  - sw (op 101011): 1 / 2 / 0 / 0 / 0
  - beq (op 000100): 0 / 0 / 0 / 0 / 0
  - j (op 000010): 3 / 3 / 0 / 0 / 0
  - jal (op 000011): 3 / 3 / 31 / 2 / 1
- Tnew = 0 for every instruction in W.
- Default case covers nop (all zero), any other op/funct, and R-type with unlisted funct:
  - Tuse_rs = Tuse_rt = 3, A3 = 0, memtoreg = 0, jalop = 0.
- An instruction with rd/rt = 0 yields A3 = 0; the consumer treats A3 = 0 as no write.
- Reset state of all outputs equals the nop decode: Tuse_rs = 3, Tuse_rt = 3, Tnew = 0, A3 = 0, memtoreg = 0, jalop = 0.
- Reset asserted mid-operation:
  - Outputs switch to the nop decode asynchronously.
  - After rst_n deasserts, the first rising edge captures instr normally.
- No X propagation: every output has a defined value for every 32-bit instr_w.

Test Plan:
- Reset with instr = 32'h0:
  - rst_n = 0 -> Tuse_rs = 3, Tuse_rt = 3, Tnew = 0, A3 = 0, memtoreg = 0, jalop = 0, with no clock edge needed.
- addu $3,$1,$2 (32'h00221821), one clock -> Tuse_rs = 1, Tuse_rt = 1, A3 = 3, memtoreg = 0, jalop = 0.
  - Outputs must be unchanged before the clock edge.
- lw $5,4($1) (32'h8C250004) -> Tuse_rs = 1, Tuse_rt = 3, A3 = 5, memtoreg = 1.
- sw $5,4($1) (32'hAC250004) -> Tuse_rs = 1, Tuse_rt = 2, A3 = 0, memtoreg = 0.
- jal (32'h0C000100) -> A3 = 31, memtoreg = 2, jalop = 1, Tuse_rs = Tuse_rt = 3.
- Mid-stream reset:
  - Load jal, pull rst_n low between edges -> outputs return immediately to the nop decode.
  - Then load beq $1,$2 (32'h10220003) -> Tuse_rs = 0, Tuse_rt = 0, A3 = 0.
- Illegal opcode 32'hFC000000 -> default decode (Tuse = 3/3, A3 = 0, memtoreg = 0, jalop = 0).

Source files
------------

// File: rtl/w_controller.sv
// ---------------------------------------------------------------------------
// w_controller : write-back (W) stage controller of the 5-stage MIPS32 core.
// It registers the instruction arriving from M and decodes it into:
//   - hazard timing fields for the forwarding/stall unit;
//   - the GRF destination register;
//   - the write-data select;
//   - the jal flag.
// Every output is a pure decode of the registered instruction, so the
// outputs show a new instruction one clock after it is captured.
// ---------------------------------------------------------------------------
module w_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic [1:0]  Tuse_rs,
  output logic [1:0]  Tuse_rt,
  output logic [1:0]  Tnew,
  output logic [4:0]  A3,
  output logic [1:0]  memtoreg,
  output logic        jalop
);

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Write-data select encodings
  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_DM    = 2'd1;
  localparam logic [1:0] WD_PC8   = 2'd2;

  // Tuse encoding for "operand not read"
  localparam logic [1:0] T_NONE   = 2'd3;

  logic [31:0] instr_w_q;
  logic [31:0] instr_w_d;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;

  assign instr_w_d = instr;

  // W stage register; reset loads a nop so the decode is defined at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_w_q <= 32'h0000_0000;
    end else begin
      instr_w_q <= instr_w_d;
    end
  end

  assign op    = instr_w_q[31:26];
  assign funct = instr_w_q[5:0];
  assign rt    = instr_w_q[20:16];
  assign rd    = instr_w_q[15:11];

  // The result of any instruction is already available once it reaches W
  assign Tnew = 2'd0;

  // Decode of the W-stage instruction; unknown encodings fall to the nop decode
  always_comb begin
    Tuse_rs  = T_NONE;
    Tuse_rt  = T_NONE;
    A3       = 5'd0;
    memtoreg = WD_ALU;
    jalop    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: begin
            Tuse_rs = 2'd1;
            Tuse_rt = 2'd1;
            A3      = rd;
          end
          FN_JR: begin
            Tuse_rs = 2'd0;
          end
          default: begin
            Tuse_rs = T_NONE;
          end
        endcase
      end
      OP_ORI: begin
        Tuse_rs = 2'd1;
        A3      = rt;
      end
      OP_LUI: begin
        A3      = rt;
      end
      OP_LW: begin
        Tuse_rs  = 2'd1;
        A3       = rt;
        memtoreg = WD_DM;
      end
      OP_SW: begin
        // store data is needed only in M, one stage later than the address
        Tuse_rs = 2'd1;
        Tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        // branch compares in D, so both operands are needed immediately
        Tuse_rs = 2'd0;
        Tuse_rt = 2'd0;
      end
      OP_J: begin
        Tuse_rs = T_NONE;
      end
      OP_JAL: begin
        A3       = 5'd31;
        memtoreg = WD_PC8;
        jalop    = 1'b1;
      end
      default: begin
        Tuse_rs = T_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_w_controller.sv
// ---------------------------------------------------------------------------
// tb_w_controller : directed bench for the W stage controller.
// Outputs are packed as {Tuse_rs, Tuse_rt, Tnew, A3, memtoreg, jalop}.
// ---------------------------------------------------------------------------
module tb_w_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [1:0]  Tuse_rs;
  logic [1:0]  Tuse_rt;
  logic [1:0]  Tnew;
  logic [4:0]  A3;
  logic [1:0]  memtoreg;
  logic        jalop;

  logic [13:0] obs;
  int          errors = 0;
  int          checks = 0;

  w_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .Tuse_rs  (Tuse_rs),
    .Tuse_rt  (Tuse_rt),
    .Tnew     (Tnew),
    .A3       (A3),
    .memtoreg (memtoreg),
    .jalop    (jalop)
  );

  assign obs = {Tuse_rs, Tuse_rt, Tnew, A3, memtoreg, jalop};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [13:0] NOP_EXP = {2'd3, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0};

  task automatic test_reset();
    rst_n = 1'b1;
    instr = 32'h0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== NOP_EXP) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", obs, NOP_EXP);
    end
    // hold reset across an edge with a live instruction on the input
    instr = 32'h0C000100;
    @(posedge clk); #1;
    checks++;
    if (obs !== NOP_EXP) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", obs, NOP_EXP);
    end
    rst_n = 1'b1;
    instr = 32'h0;
  endtask

  task automatic test_addu();
    logic [13:0] exp;
    instr = 32'h00221821;
    #1;
    checks++;
    if (obs !== NOP_EXP) begin
      errors++;
      $display("FAIL addu_before_edge got=%h exp=%h", obs, NOP_EXP);
    end
    @(posedge clk); #1;
    exp = {2'd1, 2'd1, 2'd0, 5'd3, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL addu got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_lw_sw();
    logic [13:0] exp;
    instr = 32'h8C250004;
    @(posedge clk); #1;
    exp = {2'd1, 2'd3, 2'd0, 5'd5, 2'd1, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL lw got=%h exp=%h", obs, exp);
    end
    instr = 32'hAC250004;
    @(posedge clk); #1;
    exp = {2'd1, 2'd2, 2'd0, 5'd0, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL sw got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_jal();
    logic [13:0] exp;
    instr = 32'h0C000100;
    @(posedge clk); #1;
    exp = {2'd3, 2'd3, 2'd0, 5'd31, 2'd2, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL jal got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_midstream_reset();
    logic [13:0] exp;
    instr = 32'h0C000100;
    @(posedge clk); #1;
    exp = {2'd3, 2'd3, 2'd0, 5'd31, 2'd2, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL mid_jal_loaded got=%h exp=%h", obs, exp);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== NOP_EXP) begin
      errors++;
      $display("FAIL mid_reset_async got=%h exp=%h", obs, NOP_EXP);
    end
    instr = 32'h10220003;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp = {2'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL beq_after_reset got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_illegal();
    instr = 32'hFC000000;
    @(posedge clk); #1;
    checks++;
    if (obs !== NOP_EXP) begin
      errors++;
      $display("FAIL illegal_op got=%h exp=%h", obs, NOP_EXP);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [8];
    logic [13:0] vexp [8];
    vin[0] = 32'h00430823; vexp[0] = {2'd1, 2'd1, 2'd0, 5'd1,  2'd0, 1'b0}; // subu $1,$2,$3
    vin[1] = 32'h34240005; vexp[1] = {2'd1, 2'd3, 2'd0, 5'd4,  2'd0, 1'b0}; // ori $4,$1,5
    vin[2] = 32'h3C061234; vexp[2] = {2'd3, 2'd3, 2'd0, 5'd6,  2'd0, 1'b0}; // lui $6,0x1234
    vin[3] = 32'h03E00008; vexp[3] = {2'd0, 2'd3, 2'd0, 5'd0,  2'd0, 1'b0}; // jr $31
    vin[4] = 32'h08000040; vexp[4] = {2'd3, 2'd3, 2'd0, 5'd0,  2'd0, 1'b0}; // j
    vin[5] = 32'h00220021; vexp[5] = {2'd1, 2'd1, 2'd0, 5'd0,  2'd0, 1'b0}; // addu $0,$1,$2
    vin[6] = 32'h00221820; vexp[6] = {2'd3, 2'd3, 2'd0, 5'd0,  2'd0, 1'b0}; // add: unlisted funct
    vin[7] = 32'h8C1F0000; vexp[7] = {2'd1, 2'd3, 2'd0, 5'd31, 2'd1, 1'b0}; // lw $31,0($0)
    for (int i = 0; i < 8; i++) begin
      instr = vin[i];
      @(posedge clk); #1;
      checks++;
      if (obs !== vexp[i]) begin
        errors++;
        $display("FAIL b2b[%0d] instr=%h got=%h exp=%h", i, vin[i], obs, vexp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_sw();
    test_jal();
    test_midstream_reset();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
